stack_unit: RTL and testbench
=============================

// Module: stack_unit
// PURPOSE
//  Responder side of the CU push/pop handshake: a hardware LIFO holding 16-bit words.
//  The CU raises push_req/pop_req and holds it; this block executes exactly one operation per request.
//  It answers with a one-cycle push_done/pop_done pulse and returns popped words on pop_out.
//  Sits between CU and the data-path register file; exports sp for debug and CU address logic.
// PARAMETERS
//  DEPTH   64   number of 16-bit stack entries (power of 2, 4..1024)
//  AW      6    address width, = log2(DEPTH)
// PORTS
//  clk            in   1   system clock, rising edge
//  rst_b          in   1   asynchronous reset, active-high (asserted = 1)
//  push_req       in   1   CU push request, level, held until push_done seen
//  push_data      in   16  word to push, stable while push_req=1
//  pop_req        in   1   CU pop request, level, held until pop_done seen
//  clr_err        in   1   synchronous clear of sticky error flags
//  push_done      out  1   one-cycle completion pulse for push
//  pop_done       out  1   one-cycle completion pulse for pop
//  pop_out        out  16  last popped word
//  sp             out  16  stack pointer, zero-extended from AW+1 bits
//  full           out  1   sp == 0
//  empty          out  1   sp == DEPTH
//  ovf_err        out  1   sticky: push attempted while full
//  unf_err        out  1   sticky: pop attempted while empty
//  proto_err      out  1   sticky: push_req and pop_req both high in IDLE
// BEHAVIOUR
//  Reset (async, immediate):
//   - state=IDLE, sp=DEPTH, pop_out=0, all done/err flags=0.
//   - RAM contents undefined.
//   - Reset mid-operation aborts it; no done pulse is issued.
//  Full-descending stack:
//   - push: mem[sp-1]<=push_data, sp<=sp-1.
//   - pop: pop_out<=mem[sp], sp<=sp+1.
//  FSM IDLE -> PUSH | POP -> ACK -> REL -> IDLE:
//   - IDLE: push_req&~pop_req -> PUSH; pop_req&~push_req -> POP.
//     Both high -> proto_err<=1, stay IDLE, nothing executed.
//   - PUSH: if full, ovf_err<=1, no write, sp unchanged; else write and decrement sp. -> ACK.
//   - POP: if empty, unf_err<=1, pop_out<=0, sp unchanged; else read and increment sp. -> ACK.
//   - ACK: matching done=1 for exactly this cycle.
//     pop_out is valid here and held until the next completed pop. -> REL.
//   - REL: wait until the serviced req is low, then -> IDLE.
//     Prevents a held level request from executing twice.
//  Latency: req sampled at edge E0 -> done high in the cycle after E1 -> low after E2.
//   Minimum 4 cycles per operation back-to-back.
//  Errored operations still complete the handshake; done pulses as normal.
//  Sticky errors are cleared only by reset or clr_err=1 at a clock edge.
//   Set and clear in the same cycle: set wins.
//  full, empty and sp are registered/derived from sp; they update one edge after the PUSH/POP cycle.
//  Requests arriving in PUSH/POP/ACK/REL are not sampled until IDLE.
// STRUCTURE
//  stack_defs.vh holds the state encodings (IDLE=0, PUSH=1, POP=2, ACK=3, REL=4), DEPTH/AW defaults,
//   and the word width 16. CU includes it as well.
//  Sub-module stack_ram holds the array: single port, DEPTH x 16, synchronous write,
//   synchronous read (data one edge after address).
//   POP presents address sp; data is captured into pop_out on entering ACK.
//  stack_unit holds FSM, sp counter, flags and error logic.
// TESTING
//  1 Reset: rst_b=1 mid-PUSH -> sp=64, empty=1, no push_done, pop_out=0.
//  2 Push 16'h1234, then 16'hABCD (held req, drop on done) -> each done is 1 cycle, 2 edges after req;
//    sp=63 then 62.
//  3 Pop twice -> pop_out=16'hABCD then 16'h1234, sp back to 64, empty=1, no errors.
//  4 Fill 64 pushes, push 16'h5555 -> full=1, push_done pulses, ovf_err=1, sp=0;
//    pop returns the 64th value, not 5555.
//  5 Pop on empty -> pop_done pulses, pop_out=0, unf_err=1;
//    clr_err=1 one cycle -> unf_err=0; sp stays 64.
//  6 push_req=pop_req=1 in IDLE -> proto_err=1, no done, sp unchanged.
//    Held push_req for 10 cycles -> exactly one push.

Source files
------------

// File: rtl/stack_unit_pkg.sv
// stack_unit_pkg: shared widths, default geometry and FSM state encodings for the CU stack.
package stack_unit_pkg;
    localparam int depth_default = 64;
    localparam int aw_default = 6;
    localparam int word_w = 16;
    localparam logic [2:0] st_idle = 3'd0;
    localparam logic [2:0] st_push = 3'd1;
    localparam logic [2:0] st_pop = 3'd2;
    localparam logic [2:0] st_ack = 3'd3;
    localparam logic [2:0] st_rel = 3'd4;
endpackage

// File: rtl/stack_unit_ram.sv
// stack_unit_ram: single-port DEPTH x 16 array, synchronous write and synchronous read.
module stack_unit_ram
    import stack_unit_pkg::*;
#(
    parameter int DEPTH = depth_default,
    parameter int AW = aw_default
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [word_w-1:0] wdata,
    output logic [word_w-1:0] rdata
);
    logic [word_w-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end
endmodule

// File: rtl/stack_unit.sv
// stack_unit: full-descending hardware LIFO answering the CU push/pop level handshake.
// One operation per request; REL holds off re-execution until the serviced request drops.
module stack_unit
    import stack_unit_pkg::*;
#(
    parameter int DEPTH = depth_default,
    parameter int AW = aw_default
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              push_req,
    input  logic [word_w-1:0] push_data,
    input  logic              pop_req,
    input  logic              clr_err,
    output logic              push_done,
    output logic              pop_done,
    output logic [word_w-1:0] pop_out,
    output logic [15:0]       sp,
    output logic              full,
    output logic              empty,
    output logic              ovf_err,
    output logic              unf_err,
    output logic              proto_err
);
    localparam logic [AW:0] sp_top = (AW+1)'(DEPTH);

    logic [2:0] state;
    logic op_push;
    logic [AW:0] sp_r;
    logic [AW:0] sp_dec;
    logic [word_w-1:0] rdata;
    logic ovf_set, unf_set, proto_set;

    assign sp_dec = sp_r - 1'b1;
    assign full = sp_r == '0;
    assign empty = sp_r == sp_top;
    assign sp = 16'(sp_r);
    assign push_done = (state == st_ack) && op_push;
    assign pop_done = (state == st_ack) && !op_push;
    assign ovf_set = (state == st_push) && full;
    assign unf_set = (state == st_pop) && empty;
    assign proto_set = (state == st_idle) && push_req && pop_req;

    // The read port tracks sp outside PUSH, so mem[sp] is already registered by the POP cycle.
    stack_unit_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk(clk),
        .we((state == st_push) && !full),
        .addr(state == st_push ? sp_dec[AW-1:0] : sp_r[AW-1:0]),
        .wdata(push_data),
        .rdata(rdata)
    );

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            state <= st_idle;
            op_push <= 1'b0;
            sp_r <= sp_top;
            pop_out <= '0;
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            ovf_err <= ovf_set || (ovf_err && !clr_err);
            unf_err <= unf_set || (unf_err && !clr_err);
            proto_err <= proto_set || (proto_err && !clr_err);
            case (state)
                st_idle: begin
                    if (push_req && !pop_req) begin
                        state <= st_push;
                        op_push <= 1'b1;
                    end else if (pop_req && !push_req) begin
                        state <= st_pop;
                        op_push <= 1'b0;
                    end
                end
                st_push: begin
                    if (!full) sp_r <= sp_dec;
                    state <= st_ack;
                end
                st_pop: begin
                    pop_out <= empty ? '0 : rdata;
                    if (!empty) sp_r <= sp_r + 1'b1;
                    state <= st_ack;
                end
                st_ack: state <= st_rel;
                st_rel: if (op_push ? !push_req : !pop_req) state <= st_idle;
                default: state <= st_idle;
            endcase
        end
    end
endmodule

// File: tb/tb_stack_unit.sv
// tb_stack_unit: directed and random push/pop traffic checked against a queue-based LIFO model.
module tb_stack_unit;
    logic clk = 0, rst_b = 1, push_req = 0, pop_req = 0, clr_err = 0;
    logic [15:0] push_data = 0;
    logic push_done, pop_done, full, empty, ovf_err, unf_err, proto_err;
    logic [15:0] pop_out, sp;

    int tests = 0, fails = 0;
    logic [15:0] q[$];
    logic [15:0] m_pop = 0;
    bit m_ovf = 0, m_unf = 0, m_proto = 0;

    stack_unit dut (
        .clk(clk), .rst_b(rst_b), .push_req(push_req), .push_data(push_data),
        .pop_req(pop_req), .clr_err(clr_err), .push_done(push_done), .pop_done(pop_done),
        .pop_out(pop_out), .sp(sp), .full(full), .empty(empty),
        .ovf_err(ovf_err), .unf_err(unf_err), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_sp"}, 32'(sp), 32'(64 - q.size()));
        check({tag, "_full"}, 32'(full), 32'(q.size() == 64));
        check({tag, "_empty"}, 32'(empty), 32'(q.size() == 0));
        check({tag, "_pop_out"}, 32'(pop_out), 32'(m_pop));
        check({tag, "_ovf"}, 32'(ovf_err), 32'(m_ovf));
        check({tag, "_unf"}, 32'(unf_err), 32'(m_unf));
        check({tag, "_proto"}, 32'(proto_err), 32'(m_proto));
    endtask

    // Entered and left just after a rising edge with the DUT idle.
    task automatic op(input bit is_push, input logic [15:0] d);
        int n = 0;
        bit seen = 0;
        push_req = is_push;
        pop_req = !is_push;
        push_data = d;
        while (!seen && n < 8) begin
            @(negedge clk);
            n++;
            seen = is_push ? push_done : pop_done;
        end
        check(is_push ? "push_latency" : "pop_latency", 32'(n), 32'd3);
        check("other_done", 32'(is_push ? pop_done : push_done), 32'd0);
        push_req = 0;
        pop_req = 0;
        if (is_push) begin
            if (q.size() == 64) m_ovf = 1;
            else q.push_back(d);
        end else begin
            if (q.size() == 0) begin
                m_unf = 1;
                m_pop = 0;
            end else m_pop = q.pop_back();
        end
        check_state(is_push ? "push" : "pop");
        @(negedge clk);
        check("done_width", 32'(push_done | pop_done), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_errors();
        clr_err = 1;
        @(posedge clk);
        #1;
        clr_err = 0;
        m_ovf = 0;
        m_unf = 0;
        m_proto = 0;
    endtask

    initial begin
        int dones;
        logic [15:0] sp_before;
        #12;
        @(negedge clk);
        check_state("reset");
        rst_b = 0;
        @(posedge clk);
        #1;
        // reset in the middle of a push with entries on the stack
        op(1, 16'h0f0f);
        op(1, 16'hf0f0);
        push_req = 1;
        push_data = 16'h7777;
        @(posedge clk);
        #1;
        rst_b = 1;
        #1;
        q.delete();
        m_pop = 0;
        dones = 0;
        repeat (3) begin
            @(negedge clk);
            dones += int'(push_done);
        end
        check("reset_no_done", 32'(dones), 32'd0);
        check_state("mid_reset");
        push_req = 0;
        @(posedge clk);
        #1;
        rst_b = 0;
        @(posedge clk);
        #1;
        // basic push/pop order
        op(1, 16'h1234);
        op(1, 16'hABCD);
        op(0, 16'h0);
        check("pop1", 32'(pop_out), 32'h0000ABCD);
        op(0, 16'h0);
        check("pop2", 32'(pop_out), 32'h00001234);
        // fill, overflow, drain
        for (int i = 0; i < 64; i++) op(1, 16'($urandom));
        op(1, 16'h5555);
        check("ovf_full", 32'(full), 32'd1);
        while (q.size() > 0) op(0, 16'h0);
        // underflow then clear
        op(0, 16'h0);
        clear_errors();
        @(negedge clk);
        check_state("after_clr");
        @(posedge clk);
        #1;
        // both requests together in IDLE
        op(1, 16'h2468);
        sp_before = sp;
        push_req = 1;
        pop_req = 1;
        dones = 0;
        repeat (4) begin
            @(negedge clk);
            dones += int'(push_done) + int'(pop_done);
        end
        push_req = 0;
        pop_req = 0;
        m_proto = 1;
        check("proto_no_done", 32'(dones), 32'd0);
        check("proto_sp", 32'(sp), 32'(sp_before));
        check_state("proto");
        @(posedge clk);
        #1;
        clear_errors();
        // held level request executes once
        push_req = 1;
        push_data = 16'h9999;
        dones = 0;
        repeat (10) begin
            @(negedge clk);
            dones += int'(push_done);
        end
        push_req = 0;
        q.push_back(16'h9999);
        check("held_once", 32'(dones), 32'd1);
        check_state("held");
        repeat (2) @(posedge clk);
        #1;
        // random traffic
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) == 0) clear_errors();
            op(($urandom_range(0, 2) != 0) ^ (q.size() > 8), 16'($urandom));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end
endmodule
